// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Fetches always read a full word.
  localparam logic [XLEN-1:0] FETCH_MASK = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and downstream channels around the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // Fetch port (read-only)
  logic            i_req_valid;
  logic            i_req_ready;
  logic [XLEN-1:0] i_addr;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic            i_err;

  // Load/store port
  logic            d_req_valid;
  logic            d_req_ready;
  logic [XLEN-1:0] d_addr;
  logic            d_we;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_mask;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;

  // Downstream channel
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_addr;
  logic            m_we;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_mask;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;

  logic            busy;

  // Arbiter view: serves the requesters and masters the downstream channel.
  modport master (
    input  i_req_valid, i_addr,
    output i_req_ready, i_rvalid, i_rdata, i_err,
    input  d_req_valid, d_addr, d_we, d_wdata, d_mask,
    output d_req_ready, d_rvalid, d_rdata, d_err,
    output m_valid, m_addr, m_we, m_wdata, m_mask,
    input  m_ready, m_rvalid, m_rdata,
    output busy
  );

  // Environment view: requesters plus downstream slave.
  modport slave (
    output i_req_valid, i_addr,
    input  i_req_ready, i_rvalid, i_rdata, i_err,
    output d_req_valid, d_addr, d_we, d_wdata, d_mask,
    input  d_req_ready, d_rvalid, d_rdata, d_err,
    input  m_valid, m_addr, m_we, m_wdata, m_mask,
    output m_ready, m_rvalid, m_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_starve.sv
// Data-priority winner selection with a saturating starvation counter for fetch.
module arb_prio_starve #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_valid,
  input  logic d_req_valid,
  input  logic accept,
  output logic grant_i,
  output logic grant_d
);

  logic [3:0] r_starve_cnt;
  logic       w_starved;
  logic       w_win_d;
  logic       w_win_i;

  // Pick the winner; fetch overrides data once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_starved = (r_starve_cnt == 4'(STARVE_LIMIT));
    w_win_d   = d_req_valid & ~(i_req_valid & w_starved);
    w_win_i   = i_req_valid & ~w_win_d;
    grant_d   = accept & w_win_d;
    grant_i   = accept & w_win_i;
  end

  // Count consecutive arbitrations fetch lost; clear when fetch is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (grant_i) begin
      r_starve_cnt <= 4'd0;
    end else if (grant_d && i_req_valid && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch (I) and load/store (D) requesters.
// One transaction outstanding; response is routed to its owner or replaced by a
// timeout error if the slave never answers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input logic                 clk,
  input logic                 reset,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_e        r_state;
  logic              r_owner;
  logic [XLEN-1:0]   r_addr;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_mask;
  logic              r_m_valid;
  logic [TCNT_W-1:0] r_tcnt;

  logic              w_idle;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_timeout;
  logic              w_resp;
  logic              w_i_rvalid;
  logic              w_d_rvalid;
  logic [XLEN-1:0]   w_rdata;

  assign w_idle = (r_state == ARB_IDLE);

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (bus.i_req_valid),
    .d_req_valid (bus.d_req_valid),
    .accept      (w_idle),
    .grant_i     (w_grant_i),
    .grant_d     (w_grant_d)
  );

  // Response decode: a real m_rvalid always beats a coincident timeout.
  always_comb begin
    w_timeout = 1'b0;
    if (TIMEOUT != 0) begin
      w_timeout = (r_state == ARB_WAIT) && !bus.m_rvalid &&
                  (r_tcnt == TCNT_W'(TIMEOUT - 1));
    end
    w_resp     = (r_state == ARB_WAIT) && (bus.m_rvalid || w_timeout);
    w_rdata    = bus.m_rvalid ? bus.m_rdata : '0;
    w_i_rvalid = w_resp && (r_owner == OWN_I);
    w_d_rvalid = w_resp && (r_owner == OWN_D);
  end

  assign bus.i_req_ready = w_grant_i;
  assign bus.d_req_ready = w_grant_d;
  assign bus.i_rvalid    = w_i_rvalid;
  assign bus.i_rdata     = w_i_rvalid ? w_rdata : '0;
  assign bus.i_err       = w_i_rvalid & w_timeout;
  assign bus.d_rvalid    = w_d_rvalid;
  assign bus.d_rdata     = w_d_rvalid ? w_rdata : '0;
  assign bus.d_err       = w_d_rvalid & w_timeout;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_addr      = r_addr;
  assign bus.m_we        = r_we;
  assign bus.m_wdata     = r_wdata;
  assign bus.m_mask      = r_mask;
  assign bus.busy        = !w_idle;

  // Transaction FSM: latch the winner, hold the request until m_ready, then wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_I;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_m_valid <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_owner   <= OWN_D;
            r_addr    <= bus.d_addr;
            r_we      <= bus.d_we;
            r_wdata   <= bus.d_wdata;
            r_mask    <= bus.d_mask;
            r_m_valid <= 1'b1;
            r_state   <= ARB_ISSUE;
          end else if (w_grant_i) begin
            r_owner   <= OWN_I;
            r_addr    <= bus.i_addr;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_mask    <= FETCH_MASK;
            r_m_valid <= 1'b1;
            r_state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_tcnt    <= '0;
            r_state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (w_resp) begin
            r_state <= ARB_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
